// File: rtl/acc_pkg.sv
// ============================================================================
// acc_pkg : shared types for the key accumulator (operation modes, key FSM)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package acc_pkg;

    typedef enum logic [1:0] {
        ACC_ADD  = 2'b00,
        ACC_SUB  = 2'b01,
        ACC_XOR  = 2'b10,
        ACC_HOLD = 2'b11
    } acc_mode_t;

    typedef enum logic [1:0] {
        KEY_RELEASED = 2'b00,
        KEY_PRESSED  = 2'b01,
        KEY_HELD     = 2'b10
    } key_state_t;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// key_debounce : synchronises an active-low bouncy key, emits one press pulse
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce
    import acc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press_o
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync;
    logic                   level;
    logic [CNT_W-1:0]       count;
    key_state_t             state;

    // Chain resets to "released" so a key held through reset still needs a full debounce.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], key_n};
        end
    end

    assign level = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= KEY_RELEASED;
            count <= '0;
        end else begin
            case (state)
                KEY_RELEASED: begin
                    if (level) begin
                        count <= '0;
                    end else if (count == CNT_MAX) begin
                        state <= KEY_PRESSED;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                KEY_PRESSED: begin
                    state <= KEY_HELD;
                    count <= '0;
                end
                KEY_HELD: begin
                    if (!level) begin
                        count <= '0;
                    end else if (count == CNT_MAX) begin
                        state <= KEY_RELEASED;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= KEY_RELEASED;
                    count <= '0;
                end
            endcase
        end
    end

    assign press_o = (state == KEY_PRESSED);

endmodule

`default_nettype wire

// File: rtl/key_accumulator.sv
// ============================================================================
// key_accumulator : key-driven add/sub/xor accumulator of the switch word
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module key_accumulator
    import acc_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int SATURATE        = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_i,
    input  logic             acc_key_n,
    input  logic             clr_key_n,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             ovf_o,
    output logic             upd_o
);

    logic [SYNC_STAGES-1:0][WIDTH+1:0] in_pipe;
    logic [WIDTH-1:0]                  sw_op;
    acc_mode_t                         mode_op;
    logic                              acc_press;
    logic                              clr_press;
    logic [WIDTH:0]                    sum;
    logic [WIDTH:0]                    diff;
    logic [WIDTH-1:0]                  acc_next;
    logic                              ovf_next;
    logic                              wr;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_acc_key (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (acc_key_n),
        .press_o (acc_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_clr_key (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (clr_key_n),
        .press_o (clr_press)
    );

    // Switches and mode are quasi-static, so they share one bus synchroniser.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_pipe <= '0;
        end else begin
            in_pipe <= {in_pipe[SYNC_STAGES-2:0], {mode_i, sw_i}};
        end
    end

    assign sw_op   = in_pipe[SYNC_STAGES-1][WIDTH-1:0];
    assign mode_op = acc_mode_t'(in_pipe[SYNC_STAGES-1][WIDTH+1:WIDTH]);
    assign sum     = {1'b0, acc_o} + {1'b0, sw_op};
    assign diff    = {1'b0, acc_o} - {1'b0, sw_op};

    always_comb begin
        acc_next = acc_o;
        ovf_next = ovf_o;
        wr       = 1'b0;
        if (clr_press) begin
            acc_next = '0;
            ovf_next = 1'b0;
            wr       = 1'b1;
        end else if (acc_press) begin
            case (mode_op)
                ACC_ADD: begin
                    wr       = 1'b1;
                    acc_next = sum[WIDTH-1:0];
                    if (sum[WIDTH]) begin
                        ovf_next = 1'b1;
                        if (SATURATE != 0) acc_next = '1;
                    end
                end
                ACC_SUB: begin
                    wr       = 1'b1;
                    acc_next = diff[WIDTH-1:0];
                    if (diff[WIDTH]) begin
                        ovf_next = 1'b1;
                        if (SATURATE != 0) acc_next = '0;
                    end
                end
                ACC_XOR: begin
                    wr       = 1'b1;
                    acc_next = acc_o ^ sw_op;
                end
                default: begin
                    wr       = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_o <= '0;
            ovf_o <= 1'b0;
            upd_o <= 1'b0;
        end else begin
            acc_o <= acc_next;
            ovf_o <= ovf_next;
            upd_o <= wr;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_key_accumulator.sv
// ============================================================================
// tb_key_accumulator : randomized bench for key_accumulator, wrap and saturate
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_accumulator;
    import acc_pkg::*;

    localparam int W    = 8;
    localparam int DEB  = 4;
    localparam int SYNC = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] sw = '0;
    logic         acc_key_n = 1'b1;
    logic         clr_key_n = 1'b1;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] acc, acc_s;
    logic         ovf, ovf_s, upd, upd_s;

    int tests = 0;
    int fails = 0;
    int upd_cnt = 0;
    int upd_cnt_s = 0;

    // Reference state: wrapping build and saturating build
    int m_acc = 0, m_ovf = 0, s_acc = 0, s_ovf = 0;

    always #5 clk = ~clk;

    key_accumulator #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC), .SATURATE(0)) dut (
        .clk(clk), .reset_n(reset_n), .sw_i(sw), .acc_key_n(acc_key_n), .clr_key_n(clr_key_n),
        .mode_i(mode), .acc_o(acc), .ovf_o(ovf), .upd_o(upd));

    key_accumulator #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC), .SATURATE(1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .sw_i(sw), .acc_key_n(acc_key_n), .clr_key_n(clr_key_n),
        .mode_i(mode), .acc_o(acc_s), .ovf_o(ovf_s), .upd_o(upd_s));

    always @(negedge clk) begin
        if (upd)   upd_cnt++;
        if (upd_s) upd_cnt_s++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_acc = 0; m_ovf = 0; s_acc = 0; s_ovf = 0;
    endtask

    task automatic model_op(input logic [1:0] m, input int s);
        int r;
        case (m)
            2'b00: begin
                r = m_acc + s;
                if (r > 255) m_ovf = 1;
                m_acc = r % 256;
                r = s_acc + s;
                if (r > 255) begin s_ovf = 1; s_acc = 255; end else s_acc = r;
            end
            2'b01: begin
                r = m_acc - s;
                if (r < 0) begin m_ovf = 1; r = r + 256; end
                m_acc = r;
                r = s_acc - s;
                if (r < 0) begin s_ovf = 1; s_acc = 0; end else s_acc = r;
            end
            2'b10: begin
                m_acc = m_acc ^ s;
                s_acc = s_acc ^ s;
            end
            default: ;
        endcase
    endtask

    task automatic drive_keys(input bit a, input bit c, input logic lvl, input int n);
        if (a) acc_key_n = lvl;
        if (c) clr_key_n = lvl;
        step(n);
    endtask

    // One physical press with optional bounce on both edges; sw/mode scrambled
    // while held long after the press pulse to show they are ignored there.
    task automatic press(input bit a, input bit c, input int hold, input int bounces);
        for (int b = 0; b < bounces; b++) begin
            drive_keys(a, c, 1'b0, $urandom_range(1, DEB - 1));
            drive_keys(a, c, 1'b1, $urandom_range(1, 3));
        end
        for (int i = 0; i < hold; i++) begin
            if (i >= 12) begin
                sw   = W'($urandom);
                mode = 2'($urandom);
            end
            drive_keys(a, c, 1'b0, 1);
        end
        if (bounces > 0) begin
            drive_keys(a, c, 1'b1, $urandom_range(1, 3));
            drive_keys(a, c, 1'b0, $urandom_range(1, 2));
        end
        drive_keys(a, c, 1'b1, 12);
    endtask

    task automatic check_state(input string tag, input int upd_delta, input int exp_delta,
                               input int upd_delta_s);
        check({tag, "_acc"},  32'(acc),   32'(m_acc));
        check({tag, "_ovf"},  32'(ovf),   32'(m_ovf));
        check({tag, "_upd"},  32'(upd_delta), 32'(exp_delta));
        check({tag, "_sacc"}, 32'(acc_s), 32'(s_acc));
        check({tag, "_sovf"}, 32'(ovf_s), 32'(s_ovf));
        check({tag, "_supd"}, 32'(upd_delta_s), 32'(exp_delta));
    endtask

    task automatic txn(input string tag, input logic [1:0] m, input logic [W-1:0] s,
                       input bit a, input bit c, input int hold, input int bounces);
        int b0, b1, exp_d;
        mode = m;
        sw   = s;
        step(3);
        b0 = upd_cnt;
        b1 = upd_cnt_s;
        press(a, c, hold, bounces);
        exp_d = 0;
        if (c) begin
            model_reset();
            exp_d = 1;
        end else if (a) begin
            model_op(m, int'(s));
            exp_d = (m != 2'b11) ? 1 : 0;
        end
        check_state(tag, upd_cnt - b0, exp_d, upd_cnt_s - b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, b0, b1;
        step(3);
        reset_n = 1'b1;
        step(2);
        check_state("reset", upd_cnt, 0, upd_cnt_s);

        // Clean presses with a press-to-update latency measurement on the first
        mode = ACC_ADD;
        sw   = 8'h05;
        step(3);
        b0 = upd_cnt;
        acc_key_n = 1'b0;
        lat = 21;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (upd) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'(SYNC + DEB + 2));
        step(2);
        acc_key_n = 1'b1;
        step(12);
        model_op(ACC_ADD, 5);
        check("add1_acc", 32'(acc), 32'h05);
        check("add1_upd", 32'(upd_cnt - b0), 32'd1);
        txn("add2", ACC_ADD, 8'h05, 1, 0, 8, 0);
        check("add2_lit", 32'(acc), 32'h0A);
        txn("add3", ACC_ADD, 8'h05, 1, 0, 8, 0);
        check("add3_lit", 32'(acc), 32'h0F);

        // Overflow: wrap vs clamp
        txn("clr_a", ACC_ADD, 8'h00, 0, 1, 8, 0);
        txn("xorF0", ACC_XOR, 8'hF0, 1, 0, 8, 0);
        txn("ovf_add", ACC_ADD, 8'h20, 1, 0, 8, 0);
        check("ovf_add_lit", 32'(acc), 32'h10);
        check("ovf_add_sat", 32'(acc_s), 32'hFF);

        // Underflow then clear
        txn("clr_b", ACC_ADD, 8'h00, 0, 1, 8, 0);
        txn("add03", ACC_ADD, 8'h03, 1, 0, 8, 0);
        txn("sub05", ACC_SUB, 8'h05, 1, 0, 8, 0);
        check("sub05_lit", 32'(acc), 32'hFE);
        txn("clr_c", ACC_ADD, 8'h00, 0, 1, 8, 0);

        // Fixed bounce sequence yields exactly one press
        mode = ACC_ADD;
        sw   = 8'h07;
        step(3);
        b0 = upd_cnt;
        b1 = upd_cnt_s;
        drive_keys(1, 0, 1'b0, 3);
        drive_keys(1, 0, 1'b1, 1);
        drive_keys(1, 0, 1'b0, 3);
        drive_keys(1, 0, 1'b1, 2);
        drive_keys(1, 0, 1'b0, 10);
        drive_keys(1, 0, 1'b1, 12);
        model_op(ACC_ADD, 7);
        check_state("bounce", upd_cnt - b0, 1, upd_cnt_s - b1);

        // Simultaneous clear and accumulate, long hold
        txn("both", ACC_ADD, 8'h11, 1, 1, 100, 0);
        check("both_lit", 32'(acc), 32'h00);

        // Reset mid-debounce, then reset mid-hold with the key still down
        mode = ACC_ADD;
        sw   = 8'h11;
        step(3);
        drive_keys(1, 0, 1'b0, 3);
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        drive_keys(1, 0, 1'b0, 3);
        drive_keys(1, 0, 1'b1, 12);
        drive_keys(1, 0, 1'b0, 20);
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        model_reset();
        b0 = upd_cnt;
        b1 = upd_cnt_s;
        drive_keys(1, 0, 1'b0, 3);
        drive_keys(1, 0, 1'b1, 12);
        check_state("rst_hold", upd_cnt - b0, 0, upd_cnt_s - b1);

        // Randomized transactions with bounce
        for (int i = 0; i < 16; i++) begin
            int r;
            r = $urandom_range(0, 9);
            txn($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), W'($urandom),
                (r >= 1), (r < 2), $urandom_range(6, 30), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
